// File: rtl/max_pool_ctrl_if.sv
// Handshake and control bundle between the max-pool controller and its
// surroundings (pixel source, line FIFO, pooling datapath, host).
//   start        : one-cycle frame start request
//   pool_stride  : 0 = 2x2 stride-2, 1 = 2x2 stride-1 (overlapping)
//   pix_vld      : upstream pixel valid (pixel data bypasses the controller)
//   pix_rdy      : upstream ready
//   data_in_vld  : pixel valid toward the pooling datapath
//   row_cnt      : row index of the pixel currently in the datapath
//   fifo_wr_en   : line-FIFO push of the horizontal pair maximum
//   fifo_rd_en   : line-FIFO pop (first-word-fall-through FIFO)
//   pool_out_vld : pooling datapath output valid
//   busy         : frame in progress
//   done         : one-cycle end-of-frame pulse
//   err          : sticky in-row gap flag
interface max_pool_ctrl_if;
    logic       start;
    logic       pool_stride;
    logic       pix_vld;
    logic       pix_rdy;
    logic       data_in_vld;
    logic [3:0] row_cnt;
    logic       fifo_wr_en;
    logic       fifo_rd_en;
    logic       pool_out_vld;
    logic       busy;
    logic       done;
    logic       err;

    // Drives requests and pixels, observes controller outputs.
    modport master (
        output start, pool_stride, pix_vld,
        input  pix_rdy, data_in_vld, row_cnt, fifo_wr_en, fifo_rd_en,
               pool_out_vld, busy, done, err
    );

    // The controller itself.
    modport slave (
        input  start, pool_stride, pix_vld,
        output pix_rdy, data_in_vld, row_cnt, fifo_wr_en, fifo_rd_en,
               pool_out_vld, busy, done, err
    );
endinterface

// File: rtl/max_pool_ctrl.sv
// Sequencing controller for a 2x2 max-pooling datapath with a line FIFO.
// Tracks pixel column/row within a frame, decodes line-FIFO push/pop enables
// for stride-2 or overlapping stride-1 pooling, and flags gaps inside a row.
// Ports:
//   sclk  : single clock, rising edge
//   s_rst : asynchronous, active-high reset
//   bus   : max_pool_ctrl_if.slave (handshake, FIFO enables, status)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting pixels of the frame
// FLUSH | two cycles letting the last enables drain through the pipeline
// DONE  | one-cycle end-of-frame pulse
module max_pool_ctrl #(
    parameter int COL_NUM = 16,
    parameter int ROW_NUM = 16
) (
    input  logic           sclk,
    input  logic           s_rst,
    max_pool_ctrl_if.slave bus
);
    localparam int CW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
    localparam int RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t        state_q;
    logic          flush_q;
    logic          stride_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [3:0]    row_cnt_q;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic          pov_q;
    logic          err_q;

    logic accept;
    logic col_last;
    logic row_last;

    assign accept   = (state_q == S_RUN) && bus.pix_vld;
    assign col_last = (col_q == CW'(COL_NUM - 1));
    assign row_last = (row_q == RW'(ROW_NUM - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Stage-1 enable decode from the pixel being accepted this cycle.
    always_comb begin
        wr_d = 1'b0;
        rd_d = 1'b0;
        if (accept) begin
            if (stride_q) begin
                // Overlapping windows: every column after the first closes a
                // horizontal pair; the last row is never pushed, the first
                // row is never popped.
                wr_d = (col_q != '0) && (row_q <= RW'(ROW_NUM - 2));
                rd_d = (col_q != '0) && (row_q != '0);
            end else begin
                wr_d = col_q[0] & ~row_q[0];
                rd_d = col_q[0] &  row_q[0];
            end
        end
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q   <= S_IDLE;
            flush_q   <= 1'b0;
            stride_q  <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            row_cnt_q <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            pov_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            pov_q <= rd_q;
            if (accept) begin
                row_cnt_q <= 4'(row_q);
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q  <= S_RUN;
                        stride_q <= bus.pool_stride;
                        col_q    <= '0;
                        row_q    <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!bus.pix_vld && (col_q != '0)) begin
                        err_q <= 1'b1;
                    end
                    if (accept && col_last && row_last) begin
                        state_q <= S_FLUSH;
                        flush_q <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (flush_q) begin
                        state_q <= S_DONE;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pix_rdy      = (state_q == S_RUN);
    assign bus.data_in_vld  = accept;
    assign bus.row_cnt      = row_cnt_q;
    assign bus.fifo_wr_en   = wr_q;
    assign bus.fifo_rd_en   = rd_q;
    assign bus.pool_out_vld = pov_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.err          = err_q;
endmodule

// File: doc/max_pool_ctrl.md
MAX_POOL_CTRL -- requirements
Module: max_pool_ctrl

Interface
REQ-001 Parameter COL_NUM, default 16: pixels per feature-map row; even when pool_stride=0; range 2..512.
REQ-002 Parameter ROW_NUM, default 16: rows per frame; range 2..16; even when pool_stride=0.
REQ-003 sclk  in  1  single clock; all logic rising-edge.
REQ-004 s_rst  in  1  reset, asynchronous assert, active-high.
REQ-005 start  in  1  one-cycle frame start request.
REQ-006 pool_stride  in  1  0 = 2x2 stride-2, 1 = 2x2 stride-1 (overlapping); sampled on accepted start.
REQ-007 pix_vld  in  1  upstream pixel valid; pixel data bypasses this block to the pooling datapath.
REQ-008 pix_rdy  out  1  upstream ready.
REQ-009 data_in_vld  out  1  pixel valid to pooling datapath.
REQ-010 row_cnt  out  4  current row index for the pooling datapath.
REQ-011 fifo_wr_en  out  1  line-FIFO push of horizontal pair maximum.
REQ-012 fifo_rd_en  out  1  line-FIFO pop (first-word-fall-through FIFO).
REQ-013 pool_out_vld  out  1  pooling datapath output valid this cycle.
REQ-014 busy  out  1  frame in progress.
REQ-015 done  out  1  one-cycle end-of-frame pulse.
REQ-016 err  out  1  sticky in-row gap flag.

Function
REQ-017 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start; RUN->FLUSH on acceptance of pixel (ROW_NUM-1, COL_NUM-1); FLUSH lasts 2 cycles; DONE lasts 1 cycle, then IDLE.
REQ-018 start outside IDLE is ignored; pool_stride is latched on entry to RUN and held for the frame.
REQ-019 pix_rdy = 1 only in RUN; data_in_vld = pix_vld AND pix_rdy, combinational, same cycle as the pixel.
REQ-020 Pixel accepted at cycle t advances col counter (0..COL_NUM-1, wraps to 0 and increments row counter) at the edge ending t.
REQ-021 Stage 1 (cycle t+1, registered): row_cnt = row index of pixel t (low 4 bits); fifo_wr_en and fifo_rd_en decoded from pixel t (col c, row r).
REQ-022 Stride-2: fifo_wr_en = (c odd AND r even); fifo_rd_en = (c odd AND r odd).
REQ-023 Stride-1: fifo_wr_en = (c>=1 AND r<=ROW_NUM-2); fifo_rd_en = (c>=1 AND r>=1).
REQ-024 Stage 2 (cycle t+2, registered): pool_out_vld = stage-1 fifo_rd_en delayed one cycle.
REQ-025 Output count per frame: stride-2 (COL_NUM/2)*(ROW_NUM/2); stride-1 (COL_NUM-1)*(ROW_NUM-1); pushes = pops per frame (FIFO ends empty).
REQ-026 With no pixel accepted in a cycle, stage-1 enables are 0 next cycle; row_cnt holds.
REQ-027 Gap rule: pix_vld low in RUN with col counter != 0 sets err; err clears only on reset or accepted start; counting resumes on next valid pixel.
REQ-028 busy = 1 in RUN, FLUSH, DONE; done = 1 only in DONE, coinciding with the cycle after the last pool_out_vld.
REQ-029 Counters are clog2-sized; no arithmetic overflow within parameter ranges.

Reset
REQ-030 s_rst high: state IDLE, counters 0, row_cnt=0, fifo_wr_en=0, fifo_rd_en=0, pool_out_vld=0, busy=0, done=0, err=0, pix_rdy=0 immediately (asynchronous).
REQ-031 Reset mid-frame aborts the frame with no further enables; the line FIFO is reset by the same s_rst; the first start after release begins a clean frame.

Verification
REQ-032 COL_NUM=4, ROW_NUM=4, stride 0, 16 contiguous pixels -> wr_en 2 pulses each in rows 0,2; rd_en 2 pulses each in rows 1,3; 4 pool_out_vld, each 2 cycles after pixel (odd row, odd col); done 1 pulse.
REQ-033 Same, stride 1 -> 9 wr_en (rows 0-2, cols 1-3), 9 rd_en (rows 1-3), 9 pool_out_vld; row_cnt sequence 0,1,2,3.
REQ-034 pix_vld dropped 1 cycle at row 1 col 2 -> err=1 from next cycle, remaining outputs still 4 (stride 0); err=0 after next accepted start.
REQ-035 s_rst pulsed at row 2 col 1 -> all outputs 0 within that cycle, IDLE; new start with 16 pixels yields a normal 4-output frame.
REQ-036 start re-asserted during RUN and FLUSH -> ignored, no counter disturbance; start in IDLE the cycle after done -> accepted.
